rs232_tx_serializer: RTL and testbench
======================================

// Module: rs232_tx_serializer
// PURPOSE
//  Transmit stage placed directly downstream of the byte FIFO. It pops bytes from
//  the FIFO and serialises each onto the RS232 TX line as one frame: start bit,
//  data bits LSB first, optional parity bit, then stop bit(s).
//  Paces bits with an internal baud tick and reports end-of-burst when the FIFO
//  marks the popped byte as its last.
// PARAMETERS
//  CLK_FREQ    50000000  system clock frequency, Hz
//  BAUD_RATE   115200    line rate, bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer, >= 4
//  DATA_WIDTH  8         data bits per frame, 5..8
//  PARITY      0         0 = none, 1 = odd, 2 = even
//  STOP_BITS   1         number of stop bits, 1 or 2
// PORTS
//  clk            in   1           system clock, rising edge
//  rst            in   1           synchronous, active-high reset
//  enable         in   1           0 = finish current frame, then stay idle
//  fifo_not_empty in   1           FIFO holds at least one byte
//  fifo_pop       out  1           one-cycle pop strobe to the FIFO
//  fifo_data      in   DATA_WIDTH  FIFO out_data; valid on the cycle after fifo_pop
//  fifo_last      in   1           FIFO popped_last; valid with fifo_data
//  tx             out  1           serial line, idle high
//  busy           out  1           high from the pop cycle through the end of the last stop bit
//  frame_done     out  1           one-cycle pulse after the last stop bit completes
//  burst_done     out  1           one-cycle pulse with frame_done when the frame held the FIFO's last byte
// BEHAVIOUR
//  Reset (rst=1 sampled on clk): state=IDLE, tx=1, busy=0, fifo_pop=0,
//   frame_done=0, burst_done=0, baud counter=0. Applies mid-frame: the line
//   returns high on the next edge and the partial frame is abandoned.
//  FSM states: IDLE -> POP -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   IDLE: if enable & fifo_not_empty, assert fifo_pop for one cycle and go to POP.
//   POP: wait one cycle for FIFO data.
//   LOAD: latch fifo_data into the shift register and fifo_last into last_flag;
//     compute parity = ^data, inverted for odd parity; clear the baud counter.
//   START: tx=0 for CLKS_PER_BIT clocks.
//   DATA: tx=shift[0]; shift right on each baud tick; bit counter runs 0..DATA_WIDTH-1.
//   PARITY: skipped when PARITY=0.
//   STOP: tx=1 for STOP_BITS*CLKS_PER_BIT clocks. Then pulse frame_done, and
//     burst_done=last_flag, and go to IDLE.
//  Latency: from fifo_pop to the tx falling edge is 3 clocks (POP, LOAD, then the
//   first START clock). Every bit is exactly CLKS_PER_BIT clocks long.
//  Back-to-back frames: at most 3 idle-high clocks between the end of STOP and
//   the next start bit.
//  fifo_pop is never asserted outside IDLE, so at most one pop per frame; no
//   pop happens while fifo_not_empty=0.
//  Dropping enable mid-frame does not truncate the frame. The pop is suppressed
//   only in IDLE.
//  Baud counter width is $clog2(CLKS_PER_BIT). It wraps to 0 on its tick, with
//   no drift across frames.
//  fifo_data/fifo_last are ignored in every cycle except LOAD.
// STRUCTURE
//  rs232_defs.vh: PARITY_NONE/ODD/EVEN encodings, FSM state localparams.
//  Shared with the future RX deserializer.
//  Sub-module rs232_baud_gen (clk, rst, restart, tick): a divide-by-CLKS_PER_BIT
//   counter. restart zeroes it. tick is high on the last count.
//  The FSM, shift register and bit counter stay in rs232_tx_serializer.
// TESTING  (CLK_FREQ=1600, BAUD_RATE=100 -> CLKS_PER_BIT=16)
//  1. Reset: rst high for 3 clocks with the FIFO non-empty -> tx=1, fifo_pop=0,
//     busy=0 throughout.
//  2. Byte 8'hAC, PARITY=0 -> tx shows 0,0,0,1,1,0,1,0,1,1, each bit 16 clocks,
//     160 clocks total; one fifo_pop; one frame_done; burst_done=0.
//  3. Bytes 8'h61 then 8'h11, second with fifo_last=1 -> two frames, <=3 idle
//     clocks between them; burst_done pulses only with the second frame_done.
//  4. PARITY=2 (even), 8'h7D -> parity bit 0 after the data; PARITY=1 (odd) ->
//     parity bit 1.
//  5. rst pulsed during data bit 4 of 8'h39 -> tx=1 on the next clock; no
//     frame_done; the next frame starts cleanly from IDLE.
//  6. enable dropped during the START bit with 2 bytes queued -> the current
//     frame completes, no further fifo_pop until enable=1.

Source files
------------

// File: rtl/rs232_tx_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_tx_serializer_pkg
//  Description : Shared RS232 definitions: parity mode encodings, transmit
//                FSM state encoding and a parity helper. Intended to be
//                reused by the matching RX deserializer.
//  Revision    : 1.0  initial release
// ============================================================================
package rs232_tx_serializer_pkg;

    // Parity mode encodings for the PARITY parameter
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Transmit FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_t;

    // Parity bit for a zero-extended data word; zero padding does not change
    // the XOR reduction, so one helper serves every data width from 5 to 8.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic r;
        r = ^data;
        if (mode == PARITY_ODD) begin
            r = ~r;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs232_tx_serializer_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_baud_gen
//  Description : Divide-by-CLKS_PER_BIT counter. tick is high on the last
//                count, after which the counter wraps to zero. restart zeroes
//                the counter so a frame always starts on a full bit period.
//  Revision    : 1.0  initial release
// ============================================================================
module rs232_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLKS_PER_BIT - 1);

    logic [c_CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == c_LAST);

    // Free-running bit-period counter with wrap on tick and explicit restart
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rs232_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_tx_serializer
//  Description : Pops bytes from the upstream byte FIFO and sends each as one
//                RS232 frame: start bit, data LSB first, optional parity,
//                stop bit(s). Flags frame completion and end of burst.
//  Revision    : 1.0  initial release
// ============================================================================
module rs232_tx_serializer
    import rs232_tx_serializer_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_not_empty,
    output logic                  fifo_pop,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_last,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  burst_done
);

    localparam int c_CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int c_BIT_CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [c_BIT_CNT_W-1:0] c_LAST_DATA = c_BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_BIT_CNT_W-1:0] c_LAST_STOP = c_BIT_CNT_W'(STOP_BITS - 1);

    tx_state_t               r_state;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic [c_BIT_CNT_W-1:0]  r_bit_cnt;
    logic                    r_last_flag;
    logic                    r_parity;
    logic                    r_tx;
    logic                    r_busy;
    logic                    r_fifo_pop;
    logic                    r_frame_done;
    logic                    r_burst_done;
    logic                    w_tick;
    logic                    w_restart;
    logic [7:0]              w_data_ext;

    // The baud counter is zeroed while loading so the start bit is a full period
    assign w_restart  = (r_state == ST_LOAD);
    assign w_data_ext = 8'(fifo_data);

    rs232_baud_gen #(
        .CLKS_PER_BIT (c_CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .restart (w_restart),
        .tick    (w_tick)
    );

    // Frame sequencer: pop, load, then shift out start/data/parity/stop bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_last_flag  <= 1'b0;
            r_parity     <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_fifo_pop   <= 1'b0;
            r_frame_done <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            r_fifo_pop   <= 1'b0;
            r_frame_done <= 1'b0;
            r_burst_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (enable && fifo_not_empty) begin
                        r_fifo_pop <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_POP;
                    end
                end
                ST_POP: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_shift     <= fifo_data;
                    r_last_flag <= fifo_last;
                    r_parity    <= parity_bit(w_data_ext, PARITY);
                    r_bit_cnt   <= '0;
                    r_tx        <= 1'b0;
                    r_state     <= ST_START;
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == c_LAST_DATA) begin
                            r_bit_cnt <= '0;
                            if (PARITY != PARITY_NONE) begin
                                r_tx    <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    r_tx <= 1'b1;
                    if (w_tick) begin
                        if (r_bit_cnt == c_LAST_STOP) begin
                            r_bit_cnt    <= '0;
                            r_busy       <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_burst_done <= r_last_flag;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_pop   = r_fifo_pop;
    assign frame_done = r_frame_done;
    assign burst_done = r_burst_done;

endmodule
`default_nettype wire

// File: tb/tb_rs232_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs232_tx_serializer
//  Description : Self-checking bench for rs232_tx_serializer. Three instances
//                (no / odd / even parity) share one FIFO model; only one is
//                enabled at a time. Expected line waveforms are built from
//                the frame format: start, data LSB first, parity, stop.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rs232_tx_serializer;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] d;
        logic       l;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_not_empty = 1'b0;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_last = 1'b0;
    logic       en     [3];
    logic       pop_w  [3];
    logic       tx_w   [3];
    logic       busy_w [3];
    logic       fd_w   [3];
    logic       bd_w   [3];

    int vectors = 0;
    int miscompares = 0;
    int pop_cnt [3];
    int fd_cnt  [3];

    item_t fifo_q[$];
    item_t ref_q[$];
    item_t pend;
    bit    load_next = 1'b0;

    always #5 clk = ~clk;

    // Instance index equals its PARITY setting: 0 none, 1 odd, 2 even
    for (genvar g = 0; g < 3; g++) begin : g_dut
        rs232_tx_serializer #(
            .CLK_FREQ   (1600),
            .BAUD_RATE  (100),
            .DATA_WIDTH (8),
            .PARITY     (g),
            .STOP_BITS  (1)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .enable         (en[g]),
            .fifo_not_empty (fifo_not_empty),
            .fifo_pop       (pop_w[g]),
            .fifo_data      (fifo_data),
            .fifo_last      (fifo_last),
            .tx             (tx_w[g]),
            .busy           (busy_w[g]),
            .frame_done     (fd_w[g]),
            .burst_done     (bd_w[g])
        );
    end

    // FIFO model: data for a pop appears only in the following cycle, with
    // random junk at all other times so any sampling outside LOAD shows up.
    always @(negedge clk) begin
        if (load_next) begin
            fifo_data = pend.d;
            fifo_last = pend.l;
            load_next = 1'b0;
        end else begin
            fifo_data = 8'($urandom);
            fifo_last = 1'($urandom);
        end
        for (int g = 0; g < 3; g++) begin
            if (pop_w[g] === 1'b1) begin
                pop_cnt[g]++;
                vectors++;
                if (fifo_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pop_when_empty dut%0d: pop seen with fifo empty, required no pop", g);
                end else begin
                    pend      = fifo_q.pop_front();
                    load_next = 1'b1;
                end
            end
            if (fd_w[g] === 1'b1) fd_cnt[g]++;
        end
        fifo_not_empty = (fifo_q.size() != 0);
    end

    task automatic push_item(input logic [7:0] d, input logic l);
        item_t it;
        it.d = d;
        it.l = l;
        fifo_q.push_back(it);
        ref_q.push_back(it);
    endtask

    // Send n queued frames through instance sel and check each one cycle by cycle
    task automatic run_frames(input int sel, input int n);
        item_t it;
        bit    exp_bits[$];
        int    waitc;
        int    bad;
        int    first_bad;
        logic  got;
        en[sel] = 1'b1;
        for (int k = 0; k < n; k++) begin
            it = ref_q.pop_front();
            waitc = 0;
            while (pop_w[sel] !== 1'b1 && waitc < 200) begin
                @(negedge clk);
                waitc++;
            end
            vectors++;
            if (pop_w[sel] !== 1'b1) begin
                miscompares++;
                $display("FAIL pop_timeout dut%0d frame %0d: no pop within 200 clocks", sel, k);
                en[sel] = 1'b0;
                return;
            end
            if (k > 0) begin
                vectors++;
                if (waitc + 2 > 3) begin
                    miscompares++;
                    $display("FAIL b2b_gap dut%0d: %0d idle clocks, required <= 3", sel, waitc + 2);
                end
            end
            // LOAD cycle: line still idle
            @(negedge clk);
            vectors++;
            if (tx_w[sel] !== 1'b1) begin
                miscompares++;
                $display("FAIL load_tx dut%0d: tx=%b, required 1", sel, tx_w[sel]);
            end
            // First START cycle: line low, third clock counting the pop
            @(negedge clk);
            vectors++;
            if (tx_w[sel] !== 1'b0) begin
                miscompares++;
                $display("FAIL latency dut%0d: tx=%b two clocks after pop, required 0", sel, tx_w[sel]);
            end
            exp_bits = {};
            exp_bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) exp_bits.push_back(it.d[i]);
            if (sel == 2) exp_bits.push_back(^it.d);
            if (sel == 1) exp_bits.push_back(~^it.d);
            exp_bits.push_back(1'b1);
            bad = 0;
            first_bad = -1;
            for (int c = 0; c < exp_bits.size() * CPB; c++) begin
                if (c > 0) @(negedge clk);
                got = tx_w[sel];
                if (got !== exp_bits[c / CPB] || busy_w[sel] !== 1'b1 || fd_w[sel] !== 1'b0) begin
                    bad++;
                    if (first_bad < 0) first_bad = c;
                end
            end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL waveform dut%0d data=%02h: %0d bad clocks, first at clock %0d (tx=%b busy=%b), required exact %0d-bit frame",
                         sel, it.d, bad, first_bad, tx_w[sel], busy_w[sel], exp_bits.size());
            end
            @(negedge clk);
            vectors++;
            if (fd_w[sel] !== 1'b1) begin
                miscompares++;
                $display("FAIL frame_done dut%0d: frame_done=%b, required 1", sel, fd_w[sel]);
            end
            vectors++;
            if (bd_w[sel] !== it.l) begin
                miscompares++;
                $display("FAIL burst_done dut%0d: burst_done=%b, required %b", sel, bd_w[sel], it.l);
            end
            vectors++;
            if (busy_w[sel] !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_end dut%0d: busy=%b, required 0", sel, busy_w[sel]);
            end
        end
        en[sel] = 1'b0;
    endtask

    task automatic test_reset();
        push_item(8'h55, 1'b0);
        void'(ref_q.pop_front());
        for (int g = 0; g < 3; g++) en[g] = 1'b1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                vectors++;
                if (tx_w[g] !== 1'b1 || pop_w[g] !== 1'b0 || busy_w[g] !== 1'b0 ||
                    fd_w[g] !== 1'b0 || bd_w[g] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset dut%0d: tx=%b pop=%b busy=%b fd=%b bd=%b, required 1 0 0 0 0",
                             sel_dummy(g), tx_w[g], pop_w[g], busy_w[g], fd_w[g], bd_w[g]);
                end
            end
        end
        for (int g = 0; g < 3; g++) en[g] = 1'b0;
        rst = 1'b0;
        fifo_q = {};
        repeat (3) @(negedge clk);
        vectors++;
        if (pop_cnt[0] + pop_cnt[1] + pop_cnt[2] != 0) begin
            miscompares++;
            $display("FAIL reset_pops: %0d pops, required 0", pop_cnt[0] + pop_cnt[1] + pop_cnt[2]);
        end
    endtask

    function automatic int sel_dummy(input int g);
        return g;
    endfunction

    task automatic test_single();
        int p0;
        p0 = pop_cnt[0];
        push_item(8'hAC, 1'b0);
        run_frames(0, 1);
        repeat (5) @(negedge clk);
        vectors++;
        if (pop_cnt[0] - p0 != 1) begin
            miscompares++;
            $display("FAIL single_pops: %0d pops, required 1", pop_cnt[0] - p0);
        end
    endtask

    task automatic test_back_to_back();
        push_item(8'h61, 1'b0);
        push_item(8'h11, 1'b1);
        run_frames(0, 2);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_parity();
        push_item(8'h7D, 1'b0);
        run_frames(2, 1);
        push_item(8'h7D, 1'b1);
        run_frames(1, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int n;
        for (int g = 0; g < 3; g++) begin
            n = $urandom_range(2, 4);
            for (int k = 0; k < n; k++) push_item(8'($urandom), (k == n - 1) ? 1'b1 : 1'b0);
            run_frames(g, n);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        int fd0;
        int waitc;
        item_t it;
        it.d = 8'h39;
        it.l = 1'b1;
        fifo_q.push_back(it);
        fd0 = fd_cnt[0];
        en[0] = 1'b1;
        waitc = 0;
        while (pop_w[0] !== 1'b1 && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        repeat (2) @(negedge clk);
        en[0] = 1'b0;
        // now in the first START clock; move to the middle of data bit 4
        repeat (CPB + 4 * CPB + 8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid tx/busy: tx=%b busy=%b, required 1 0", tx_w[0], busy_w[0]);
        end
        repeat (200) @(negedge clk);
        vectors++;
        if (fd_cnt[0] != fd0) begin
            miscompares++;
            $display("FAIL reset_mid frame_done: %0d pulses, required 0", fd_cnt[0] - fd0);
        end
        push_item(8'($urandom), 1'b1);
        run_frames(0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_enable_drop();
        int p0;
        int fd0;
        int waitc;
        item_t it;
        it.d = 8'hA5;
        it.l = 1'b0;
        fifo_q.push_back(it);
        push_item(8'h3C, 1'b1);
        p0  = pop_cnt[0];
        fd0 = fd_cnt[0];
        en[0] = 1'b1;
        waitc = 0;
        while (pop_w[0] !== 1'b1 && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        repeat (3) @(negedge clk);
        en[0] = 1'b0;
        waitc = 0;
        while (fd_w[0] !== 1'b1 && waitc < 400) begin
            @(negedge clk);
            waitc++;
        end
        vectors++;
        if (fd_w[0] !== 1'b1 || waitc < 150) begin
            miscompares++;
            $display("FAIL enable_drop_complete: frame_done after %0d clocks, required full frame", waitc);
        end
        repeat (60) @(negedge clk);
        vectors++;
        if (pop_cnt[0] - p0 != 1 || fifo_q.size() != 1) begin
            miscompares++;
            $display("FAIL enable_drop_pops: %0d pops, fifo holds %0d, required 1 pop and 1 left",
                     pop_cnt[0] - p0, fifo_q.size());
        end
        vectors++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_drop_idle: tx=%b busy=%b, required 1 0", tx_w[0], busy_w[0]);
        end
        run_frames(0, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            en[g]      = 1'b0;
            pop_cnt[g] = 0;
            fd_cnt[g]  = 0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_parity();
        test_random();
        test_reset_mid_frame();
        test_enable_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
